// File: rtl/imm_gen_queue.sv
// RISC-V immediate generator feeding a DEPTH-entry valid/ready output queue.
// Optional CSR-immediate decode is enabled by defining IMM_GEN_ZICSR_EN.
module imm_gen_queue #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned DEPTH = 2,
  parameter int unsigned TAG_W = 32
) (
  input  logic                     clk,
  input  logic                     nrst,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [31:0]              in_inst,
  input  logic [TAG_W-1:0]         in_tag,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [XLEN-1:0]          out_imm,
  output logic [2:0]               out_type,
  output logic [TAG_W-1:0]         out_tag,
  output logic                     out_illegal,
  output logic [$clog2(DEPTH):0]   occupancy
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  typedef enum logic [2:0] {
    T_NONE = 3'd0,
    T_I    = 3'd1,
    T_S    = 3'd2,
    T_SB   = 3'd3,
    T_UJ   = 3'd4,
    T_U    = 3'd5,
    T_CSR  = 3'd6
  } imm_type_e;

  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_IMM32  = 7'b0011011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_OP32   = 7'b0111011;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  logic [XLEN-1:0] dec_imm;
  imm_type_e       dec_type;
  logic            dec_ill;
  logic            sgn;
  logic            unused_funct3;

  assign sgn           = in_inst[31];
  assign unused_funct3 = ^in_inst[14:12];

  always_comb begin
    dec_imm  = '0;
    dec_type = T_NONE;
    dec_ill  = 1'b0;
    case (in_inst[6:0])
      OP_IMM, OP_LOAD, OP_JALR: begin
        dec_type = T_I;
        dec_imm  = {{(XLEN-12){sgn}}, in_inst[31:20]};
      end
      OP_IMM32: begin
        if (XLEN == 64) begin
          dec_type = T_I;
          dec_imm  = {{(XLEN-12){sgn}}, in_inst[31:20]};
        end else begin
          dec_ill = 1'b1;
        end
      end
      OP_STORE: begin
        dec_type = T_S;
        dec_imm  = {{(XLEN-12){sgn}}, in_inst[31:25], in_inst[11:7]};
      end
      OP_BRANCH: begin
        dec_type = T_SB;
        dec_imm  = {{(XLEN-13){sgn}}, in_inst[31], in_inst[7], in_inst[30:25],
                    in_inst[11:8], 1'b0};
      end
      OP_JAL: begin
        dec_type = T_UJ;
        dec_imm  = {{(XLEN-21){sgn}}, in_inst[31], in_inst[19:12], in_inst[20],
                    in_inst[30:21], 1'b0};
      end
      OP_LUI, OP_AUIPC: begin
        // bit 31 sits inside the replication so the XLEN=32 case needs no zero-width fill
        dec_type = T_U;
        dec_imm  = {{(XLEN-31){sgn}}, in_inst[30:12], 12'b0};
      end
      OP_OP: ;
      OP_OP32: dec_ill = (XLEN != 64);
      OP_SYSTEM: begin
`ifdef IMM_GEN_ZICSR_EN
        if (in_inst[14]) begin
          dec_type = T_CSR;
          dec_imm  = {{(XLEN-5){1'b0}}, in_inst[19:15]};
        end else begin
          dec_type = T_I;
          dec_imm  = {{(XLEN-12){sgn}}, in_inst[31:20]};
        end
`else
        dec_type = T_I;
        dec_imm  = {{(XLEN-12){sgn}}, in_inst[31:20]};
`endif
      end
      default: dec_ill = 1'b1;
    endcase
  end

  logic [XLEN-1:0]  imm_q  [DEPTH];
  imm_type_e        type_q [DEPTH];
  logic [TAG_W-1:0] tag_q  [DEPTH];
  logic             ill_q  [DEPTH];

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          push, pop;

  assign in_ready  = (cnt_q != CW'(DEPTH));
  assign out_valid = (cnt_q != '0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  assign occupancy = cnt_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
      case ({push, pop})
        2'b10:   cnt_d = cnt_q + CW'(1);
        2'b01:   cnt_d = cnt_q - CW'(1);
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Payload needs no reset: every output is masked by out_valid.
  always_ff @(posedge clk) begin
    if (push && !flush) begin
      imm_q[wr_ptr_q]  <= dec_imm;
      type_q[wr_ptr_q] <= dec_type;
      tag_q[wr_ptr_q]  <= in_tag;
      ill_q[wr_ptr_q]  <= dec_ill;
    end
  end

  assign out_imm     = out_valid ? imm_q[rd_ptr_q]  : '0;
  assign out_type    = out_valid ? type_q[rd_ptr_q] : T_NONE;
  assign out_tag     = out_valid ? tag_q[rd_ptr_q]  : '0;
  assign out_illegal = out_valid ? ill_q[rd_ptr_q]  : 1'b0;

endmodule

// File: tb/tb_imm_gen_queue.sv
// Bench for imm_gen_queue: XLEN=32 and XLEN=64 instances share one stimulus
// stream and are checked every cycle against a queue-based reference model.
module tb_imm_gen_queue;

  localparam int DEPTH = 2;
  localparam int TAG_W = 32;
  localparam int OW    = $clog2(DEPTH) + 1;

  logic             clk = 1'b0;
  logic             nrst, flush, in_valid, out_ready;
  logic [31:0]      in_inst;
  logic [TAG_W-1:0] in_tag;

  logic             in_ready_a, out_valid_a, out_illegal_a;
  logic [31:0]      out_imm_a;
  logic [2:0]       out_type_a;
  logic [TAG_W-1:0] out_tag_a;
  logic [OW-1:0]    occ_a;

  logic             in_ready_b, out_valid_b, out_illegal_b;
  logic [63:0]      out_imm_b;
  logic [2:0]       out_type_b;
  logic [TAG_W-1:0] out_tag_b;
  logic [OW-1:0]    occ_b;

  always #5 clk = ~clk;

  imm_gen_queue #(.XLEN(32), .DEPTH(DEPTH), .TAG_W(TAG_W)) dut32 (
    .clk(clk), .nrst(nrst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready_a),
    .in_inst(in_inst), .in_tag(in_tag), .out_valid(out_valid_a), .out_ready(out_ready),
    .out_imm(out_imm_a), .out_type(out_type_a), .out_tag(out_tag_a),
    .out_illegal(out_illegal_a), .occupancy(occ_a)
  );

  imm_gen_queue #(.XLEN(64), .DEPTH(DEPTH), .TAG_W(TAG_W)) dut64 (
    .clk(clk), .nrst(nrst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready_b),
    .in_inst(in_inst), .in_tag(in_tag), .out_valid(out_valid_b), .out_ready(out_ready),
    .out_imm(out_imm_b), .out_type(out_type_b), .out_tag(out_tag_b),
    .out_illegal(out_illegal_b), .occupancy(occ_b)
  );

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference decode: signed slices widened by assignment, then truncated to xlen.
  function automatic void model_dec(input logic [31:0] inst, input int xlen,
                                    output logic [63:0] imm, output logic [2:0] typ,
                                    output logic ill);
    logic signed [11:0] i12;
    logic signed [11:0] s12;
    logic signed [12:0] b13;
    logic signed [20:0] j21;
    logic signed [31:0] u32;
    longint             v;
    i12 = inst[31:20];
    s12 = {inst[31:25], inst[11:7]};
    b13 = {inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
    j21 = {inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
    u32 = {inst[31:12], 12'h000};
    typ = 3'd0;
    ill = 1'b0;
    v   = 0;
    case (inst[6:0])
      7'h13, 7'h03, 7'h67: begin typ = 3'd1; v = i12; end
      7'h1B: if (xlen == 64) begin typ = 3'd1; v = i12; end else ill = 1'b1;
      7'h23: begin typ = 3'd2; v = s12; end
      7'h63: begin typ = 3'd3; v = b13; end
      7'h6F: begin typ = 3'd4; v = j21; end
      7'h37, 7'h17: begin typ = 3'd5; v = u32; end
      7'h33: ;
      7'h3B: if (xlen != 64) ill = 1'b1;
      7'h73: begin
`ifdef IMM_GEN_ZICSR_EN
        if (inst[14]) begin typ = 3'd6; v = longint'(inst[19:15]); end
        else begin typ = 3'd1; v = i12; end
`else
        typ = 3'd1; v = i12;
`endif
      end
      default: ill = 1'b1;
    endcase
    imm = (xlen == 64) ? 64'(v) : {32'h0, v[31:0]};
  endfunction

  typedef struct {
    logic [31:0]      inst;
    logic [TAG_W-1:0] tag;
  } ent_t;

  ent_t mq[$];
  ent_t new_e;
  bit   m_push, m_pop;
  bit   chk_en = 1'b0;

  initial forever begin
    @(posedge clk or negedge nrst);
    if (!nrst || flush) begin
      mq.delete();
    end else begin
      m_push = in_valid && (mq.size() != DEPTH);
      m_pop  = out_ready && (mq.size() != 0);
      new_e.inst = in_inst;
      new_e.tag  = in_tag;
      if (m_pop) void'(mq.pop_front());
      if (m_push) mq.push_back(new_e);
    end
  end

  task automatic cmp_dut(input string nm, input int xlen, input logic rdy, input logic vld,
                         input logic [63:0] imm, input logic [2:0] typ,
                         input logic [TAG_W-1:0] tag, input logic ill, input logic [OW-1:0] occ);
    logic [63:0] ei;
    logic [2:0]  et;
    logic        el;
    chk({nm, ".in_ready"}, rdy, mq.size() != DEPTH);
    chk({nm, ".occupancy"}, occ, mq.size());
    chk({nm, ".out_valid"}, vld, mq.size() != 0);
    if (mq.size() != 0) begin
      model_dec(mq[0].inst, xlen, ei, et, el);
      chk({nm, ".out_imm"}, imm, ei);
      chk({nm, ".out_type"}, typ, et);
      chk({nm, ".out_illegal"}, ill, el);
      chk({nm, ".out_tag"}, tag, mq[0].tag);
    end else begin
      chk({nm, ".out_imm_empty"}, imm, 0);
      chk({nm, ".out_type_empty"}, typ, 0);
      chk({nm, ".out_illegal_empty"}, ill, 0);
      chk({nm, ".out_tag_empty"}, tag, 0);
    end
  endtask

  initial forever begin
    @(negedge clk);
    if (chk_en) begin
      cmp_dut("x32", 32, in_ready_a, out_valid_a, {32'h0, out_imm_a}, out_type_a,
              out_tag_a, out_illegal_a, occ_a);
      cmp_dut("x64", 64, in_ready_b, out_valid_b, out_imm_b, out_type_b,
              out_tag_b, out_illegal_b, occ_b);
    end
  end

  task automatic step(input logic v, input logic [31:0] inst, input logic [TAG_W-1:0] tag,
                      input logic ordy, input logic fl);
    in_valid  = v;
    in_inst   = inst;
    in_tag    = tag;
    out_ready = ordy;
    flush     = fl;
    @(posedge clk);
    @(negedge clk);
  endtask

  logic [31:0]      vec [12];
  logic [63:0]      p_imm;
  logic [2:0]       p_typ;
  logic             p_ill;
  logic [TAG_W-1:0] stag;
  bit               acc;

  initial begin
    nrst = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_inst = '0; in_tag = '0;
    vec = '{32'h0010009B, 32'h0000003B, 32'h00000033, 32'h3401D073,
            32'h34011073, 32'h00C58503, 32'h00008067, 32'hFE0008E3,
            32'hFF5FF06F, 32'h12345017, 32'h0000007F, 32'hFFF5C593};

    model_dec(32'hFFF00093, 32, p_imm, p_typ, p_ill);
    chk("pin_addi_imm", p_imm, 64'h00000000FFFFFFFF);
    chk("pin_addi_type", p_typ, 1);
    model_dec(32'h00000463, 32, p_imm, p_typ, p_ill);
    chk("pin_beq_imm", p_imm, 8);
    model_dec(32'h0080006F, 32, p_imm, p_typ, p_ill);
    chk("pin_jal_imm", p_imm, 8);
    model_dec(32'hFE112E23, 32, p_imm, p_typ, p_ill);
    chk("pin_sw_imm", p_imm, 64'h00000000FFFFFFFC);
    model_dec(32'h800000B7, 64, p_imm, p_typ, p_ill);
    chk("pin_lui64_imm", p_imm, 64'hFFFFFFFF80000000);
    model_dec(32'h0000007F, 32, p_imm, p_typ, p_ill);
    chk("pin_bad_ill", p_ill, 1);

    #1 chk_en = 1'b1;
    repeat (2) @(negedge clk);
    nrst = 1'b1;
    chk("rst_occ", occ_a, 0);
    chk("rst_valid", out_valid_a, 0);
    chk("rst_ready", in_ready_a, 1);
    chk("rst_imm", out_imm_b, 0);

    step(1'b1, 32'hFFF00093, 32'd1, 1'b1, 1'b0);
    chk("addi_valid", out_valid_a, 1);
    chk("addi_type", out_type_a, 1);
    chk("addi_imm", out_imm_a, 32'hFFFFFFFF);
    chk("addi_occ", occ_a, 1);
    step(1'b0, 32'h0, 32'd0, 1'b1, 1'b0);
    chk("addi_occ_after", occ_a, 0);

    step(1'b1, 32'h00000463, 32'd2, 1'b0, 1'b0);
    step(1'b1, 32'h0080006F, 32'd3, 1'b0, 1'b0);
    chk("full_occ", occ_a, 2);
    chk("full_ready", in_ready_a, 0);
    step(1'b1, 32'h00100093, 32'd4, 1'b0, 1'b0);
    chk("full_push_ignored", occ_a, 2);
    chk("head_beq_type", out_type_a, 3);
    chk("head_beq_imm", out_imm_a, 8);
    step(1'b0, 32'h0, 32'd0, 1'b1, 1'b0);
    chk("head_jal_type", out_type_a, 4);
    chk("head_jal_imm", out_imm_a, 8);
    chk("head_jal_tag", out_tag_a, 3);
    step(1'b0, 32'h0, 32'd0, 1'b1, 1'b0);
    step(1'b0, 32'h0, 32'd0, 1'b1, 1'b0);
    chk("empty_pop_ignored", occ_a, 0);

    step(1'b1, 32'hFE112E23, 32'd5, 1'b1, 1'b0);
    chk("sw_imm", out_imm_a, 32'hFFFFFFFC);
    chk("sw_type", out_type_a, 2);
    step(1'b1, 32'h800000B7, 32'd6, 1'b1, 1'b0);
    chk("lui64_imm", out_imm_b, 64'hFFFFFFFF80000000);
    chk("lui32_imm", out_imm_a, 32'h80000000);
    step(1'b0, 32'h0, 32'd0, 1'b1, 1'b0);

    for (int i = 0; i < 12; i++) begin
      step(1'b1, vec[i], TAG_W'(10 + i), 1'b1, 1'b0);
      if (i == 10) begin
        chk("bad_illegal", out_illegal_a, 1);
        chk("bad_imm", out_imm_a, 0);
      end
`ifdef IMM_GEN_ZICSR_EN
      if (i == 3) begin
        chk("csrrwi_type", out_type_a, 6);
        chk("csrrwi_imm", out_imm_a, 3);
      end
`endif
    end
    step(1'b0, 32'h0, 32'd0, 1'b1, 1'b0);

    step(1'b1, 32'h00500093, 32'd100, 1'b0, 1'b0);
    step(1'b1, 32'h00600093, 32'd101, 1'b0, 1'b0);
    chk("stream_full_ready", in_ready_a, 0);
    stag = 32'd102;
    for (int i = 0; i < 8; i++) begin
      acc = (mq.size() != DEPTH);
      step(1'b1, {stag[11:0], 20'h00093}, stag, 1'b1, 1'b0);
      if (acc) stag++;
    end
    chk("stream_tags_accepted", stag, 109);
    step(1'b0, 32'h0, 32'd0, 1'b1, 1'b0);
    step(1'b0, 32'h0, 32'd0, 1'b1, 1'b0);
    chk("stream_drained", occ_a, 0);

    step(1'b1, 32'h00700093, 32'd200, 1'b0, 1'b0);
    step(1'b1, 32'h00800093, 32'd201, 1'b0, 1'b0);
    step(1'b1, 32'h00900093, 32'd202, 1'b1, 1'b1);
    chk("flush_occ", occ_a, 0);
    chk("flush_valid", out_valid_a, 0);
    step(1'b0, 32'h0, 32'd0, 1'b1, 1'b0);
    chk("flush_no_ghost", out_valid_a, 0);
    step(1'b1, 32'h00A00093, 32'd203, 1'b0, 1'b0);
    step(1'b1, 32'h00B00093, 32'd204, 1'b1, 1'b1);
    chk("flush_beats_push", occ_b, 0);

    step(1'b1, 32'h00C00093, 32'd300, 1'b0, 1'b0);
    step(1'b1, 32'h00D00093, 32'd301, 1'b0, 1'b0);
    #2 nrst = 1'b0;
    #1;
    chk("midrst_occ", occ_a, 0);
    chk("midrst_valid", out_valid_b, 0);
    chk("midrst_imm", out_imm_a, 0);
    @(negedge clk);
    nrst = 1'b1;
    step(1'b0, 32'h0, 32'd0, 1'b1, 1'b0);

    for (int i = 0; i < 40; i++) begin
      step((i % 3) != 0, vec[i % 12], TAG_W'(400 + i), (i % 4) != 1, i == 25);
    end
    step(1'b0, 32'h0, 32'd0, 1'b1, 1'b0);
    step(1'b0, 32'h0, 32'd0, 1'b1, 1'b0);

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
